// File: rtl/btn_mode_select_pkg.sv
// Shared definitions for the pushbutton mode selector and the LED driver that
// consumes its mode code.
package btn_mode_select_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_e;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON_A  = 2'd1;
  localparam logic [1:0] MODE_ON_B  = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;

  // Short presses walk OFF -> ON_A -> ON_B -> BLINK -> OFF.
  function automatic logic [1:0] next_mode(input logic [1:0] m);
    return m + 2'd1;
  endfunction

  // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus a run-length debouncer: the output level follows
// the synchronized input only after it has disagreed for DEBOUNCE_CNT cycles.
module btn_debounce
  import btn_mode_select_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int            CW       = cnt_width(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Any cycle of agreement restarts the run, so a glitch can never accumulate.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = level_q;

endmodule

// File: rtl/btn_mode_select.sv
// Pushbutton mode selector: short presses step the LED mode, a long press
// forces it off. All outputs come straight from registers.
module btn_mode_select
  import btn_mode_select_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 500_000,
  parameter int LONG_CNT     = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       btn_level,
  output logic [1:0] mode,
  output logic       press_pulse,
  output logic       long_pulse
);

  localparam int            HW        = cnt_width(LONG_CNT);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CNT - 1);

  logic          level;
  logic          level_prev_q;
  btn_state_e    state_q;
  logic [HW-1:0] hold_cnt_q;
  logic [HW-1:0] hold_cnt_d;
  logic          long_hit;
  logic [1:0]    mode_q;
  logic          press_q;
  logic          long_q;

  btn_debounce #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_debounce (
    .clk (clk),
    .rst (rst),
    .din (btn),
    .dout(level)
  );

  // A press turns long on the edge where the hold count lands on LONG_CNT-1;
  // that wins even if the level is already low on the same edge.
  assign hold_cnt_d = hold_cnt_q + HW'(1);
  assign long_hit   = (hold_cnt_d == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      level_prev_q <= 1'b0;
      hold_cnt_q   <= '0;
      mode_q       <= MODE_OFF;
      press_q      <= 1'b0;
      long_q       <= 1'b0;
    end else begin
      level_prev_q <= level;
      press_q      <= 1'b0;
      long_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (level && !level_prev_q) begin
            state_q    <= ST_PRESSED;
            hold_cnt_q <= '0;
          end
        end
        ST_PRESSED: begin
          hold_cnt_q <= hold_cnt_d;
          if (long_hit) begin
            state_q <= ST_HELD;
            mode_q  <= MODE_OFF;
            long_q  <= 1'b1;
          end else if (!level) begin
            state_q <= ST_IDLE;
            mode_q  <= next_mode(mode_q);
            press_q <= 1'b1;
          end
        end
        ST_HELD: begin
          if (!level) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign btn_level   = level;
  assign mode        = mode_q;
  assign press_pulse = press_q;
  assign long_pulse  = long_q;

endmodule
